// File: rtl/core_pipe_cf_arbiter.sv
// Arbitrates trap and CFU redirects onto the fetch control-flow bus, flushes the
// pipe on acceptance and marks wrong-path instruction responses for discard.
module core_pipe_cf_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CW              = 3
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        trap_req,
  input  logic [63:0] trap_target,
  output logic        trap_ack,
  input  logic        cfu_req,
  input  logic [63:0] cfu_target,
  output logic        cfu_ack,
  output logic        fetch_cf_valid,
  input  logic        fetch_cf_ack,
  output logic [63:0] fetch_cf_target,
  output logic        pipe_flush,
  input  logic        imem_req_fire,
  input  logic        imem_rsp_fire,
  output logic        imem_req_allow,
  output logic        imem_rsp_discard,
  output logic        busy
);

  // Handshake: a source holds req/target until its ack; fetch_cf_valid stays
  // high with a stable target until fetch_cf_ack, and ack is ignored otherwise.
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  localparam logic [CW-1:0] MAX_O = CW'(MAX_OUTSTANDING);

  state_t        state_q, state_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [63:0]   target_q, target_d;
  logic          grant_trap_q, grant_trap_d;
  logic          ack_fire;
  logic          rsp_dec;

  // A response with nothing in flight is ignored unless a request fires with it.
  always_comb begin
    rsp_dec       = imem_rsp_fire && ((outstanding_q != '0) || imem_req_fire);
    outstanding_d = outstanding_q + CW'(imem_req_fire) - CW'(rsp_dec);
  end

  assign ack_fire       = (state_q == REQ) && fetch_cf_ack;
  assign fetch_cf_valid = (state_q == REQ);
  assign fetch_cf_target = target_q;
  assign trap_ack       = ack_fire && grant_trap_q;
  assign cfu_ack        = ack_fire && !grant_trap_q;
  assign pipe_flush     = ack_fire;
  assign imem_req_allow = (outstanding_q < MAX_O);
  assign busy           = (state_q != IDLE);

  always_comb begin
    state_d          = state_q;
    discard_d        = discard_q;
    target_d         = target_q;
    grant_trap_d     = grant_trap_q;
    imem_rsp_discard = 1'b0;
    case (state_q)
      IDLE: begin
        if (trap_req) begin
          target_d     = trap_target;
          grant_trap_d = 1'b1;
          state_d      = REQ;
        end else if (cfu_req) begin
          target_d     = cfu_target;
          grant_trap_d = 1'b0;
          state_d      = REQ;
        end
      end
      REQ: begin
        // Everything still in flight after this cycle belongs to the old path.
        if (fetch_cf_ack) begin
          imem_rsp_discard = imem_rsp_fire;
          discard_d        = outstanding_d;
          state_d          = (outstanding_d != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (imem_rsp_fire) begin
          imem_rsp_discard = 1'b1;
          discard_d        = discard_q - 1'b1;
          if (discard_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      discard_q     <= '0;
      target_q      <= '0;
      grant_trap_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      target_q      <= target_d;
      grant_trap_q  <= grant_trap_d;
    end
  end

endmodule

// File: tb/tb_core_pipe_cf_arbiter.sv
// Bench for core_pipe_cf_arbiter: directed redirect/drain scenarios checked against
// a cycle model of the arbitration and stale-response rules.
module tb_core_pipe_cf_arbiter;

  localparam int MAXO = 2;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        trap_req, cfu_req, fetch_cf_ack, imem_req_fire, imem_rsp_fire;
  logic [63:0] trap_target, cfu_target;
  logic        trap_ack, cfu_ack, fetch_cf_valid, pipe_flush;
  logic        imem_req_allow, imem_rsp_discard, busy;
  logic [63:0] fetch_cf_target;

  int checks   = 0;
  int failures = 0;

  core_pipe_cf_arbiter #(.MAX_OUTSTANDING(MAXO), .CW(3)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .trap_req(trap_req), .trap_target(trap_target), .trap_ack(trap_ack),
    .cfu_req(cfu_req), .cfu_target(cfu_target), .cfu_ack(cfu_ack),
    .fetch_cf_valid(fetch_cf_valid), .fetch_cf_ack(fetch_cf_ack),
    .fetch_cf_target(fetch_cf_target), .pipe_flush(pipe_flush),
    .imem_req_fire(imem_req_fire), .imem_rsp_fire(imem_rsp_fire),
    .imem_req_allow(imem_req_allow), .imem_rsp_discard(imem_rsp_discard),
    .busy(busy)
  );

  // clock / reset
  always #5 g_clk = ~g_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: m_grant 0=none 1=trap 2=cfu; m_stale = wrong-path responses still owed.
  int          m_out, m_stale, m_grant;
  logic [63:0] m_tgt;

  always @(posedge g_clk or posedge g_reset) begin : model
    int   n;
    logic acc;
    if (g_reset) begin
      m_out   <= 0;
      m_stale <= 0;
      m_grant <= 0;
      m_tgt   <= '0;
    end else begin
      acc = (m_grant != 0) && fetch_cf_ack;
      n   = m_out + int'(imem_req_fire) - int'(imem_rsp_fire);
      if (n < 0) n = 0;
      m_out <= n;
      if (acc) begin
        m_stale <= n;
        m_grant <= 0;
      end else if (m_stale > 0) begin
        if (imem_rsp_fire) m_stale <= m_stale - 1;
      end else if (m_grant == 0) begin
        if (trap_req) begin
          m_grant <= 1;
          m_tgt   <= trap_target;
        end else if (cfu_req) begin
          m_grant <= 2;
          m_tgt   <= cfu_target;
        end
      end
    end
  end

  // compare process
  always @(negedge g_clk) begin : compare
    logic acc;
    if (!g_reset) begin
      acc = (m_grant != 0) && fetch_cf_ack;
      check("valid",   fetch_cf_valid,   m_grant != 0);
      check("target",  fetch_cf_target,  m_tgt);
      check("trap_ack", trap_ack,        acc && (m_grant == 1));
      check("cfu_ack", cfu_ack,          acc && (m_grant == 2));
      check("flush",   pipe_flush,       acc);
      check("discard", imem_rsp_discard, imem_rsp_fire && (acc || m_stale > 0));
      check("busy",    busy,             (m_grant != 0) || (m_stale > 0));
      check("allow",   imem_req_allow,   m_out < MAXO);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap_req = 0; cfu_req = 0; fetch_cf_ack = 0;
    imem_req_fire = 0; imem_rsp_fire = 0;
  endtask

  initial begin
    idle_inputs();
    trap_target = '0;
    cfu_target  = '0;
    g_reset     = 1'b1;
    #2;
    check("rst_valid", fetch_cf_valid, 1'b0);
    check("rst_target", fetch_cf_target, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_allow", imem_req_allow, 1'b1);
    check("rst_discard", imem_rsp_discard, 1'b0);
    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;
    step();

    // single CFU redirect, nothing in flight
    cfu_target = 64'h8000_0100; cfu_req = 1;
    #1 check("t1_idle_valid", fetch_cf_valid, 1'b0);
    step();
    check("t1_valid", fetch_cf_valid, 1'b1);
    check("t1_target", fetch_cf_target, 64'h8000_0100);
    step(); step();
    fetch_cf_ack = 1;
    #1 check("t1_cfu_ack", cfu_ack, 1'b1);
    check("t1_flush", pipe_flush, 1'b1);
    check("t1_trap_ack", trap_ack, 1'b0);
    step();
    idle_inputs();
    #1 check("t1_done_busy", busy, 1'b0);

    // simultaneous requests: trap first, CFU after returning to IDLE
    trap_target = 64'h8000_0004; cfu_target = 64'h8000_0200;
    trap_req = 1; cfu_req = 1;
    step();
    check("t2_trap_target", fetch_cf_target, 64'h8000_0004);
    fetch_cf_ack = 1;
    #1 check("t2_trap_ack", trap_ack, 1'b1);
    check("t2_no_cfu_ack", cfu_ack, 1'b0);
    step();
    trap_req = 0; fetch_cf_ack = 0;
    #1 check("t2_gap_valid", fetch_cf_valid, 1'b0);
    step();
    check("t2_cfu_target", fetch_cf_target, 64'h8000_0200);
    fetch_cf_ack = 1;
    #1 check("t2_cfu_ack", cfu_ack, 1'b1);
    step();
    idle_inputs();

    // drain of three stale responses, one new-path request in between
    imem_req_fire = 1;
    step(); step();
    imem_req_fire = 0;
    #1 check("t3_allow_full", imem_req_allow, 1'b0);
    cfu_target = 64'h8000_0300; cfu_req = 1;
    step();
    fetch_cf_ack = 1; imem_req_fire = 1;
    #1 check("t3_flush", pipe_flush, 1'b1);
    step();
    idle_inputs();
    #1 check("t3_drain_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      imem_rsp_fire = 1;
      imem_req_fire = (i == 0);
      #1 check("t3_stale_discard", imem_rsp_discard, 1'b1);
      check("t3_stale_busy", busy, 1'b1);
      step();
    end
    imem_req_fire = 0; imem_rsp_fire = 1;
    #1 check("t3_fresh_discard", imem_rsp_discard, 1'b0);
    check("t3_fresh_busy", busy, 1'b0);
    step();
    idle_inputs();

    // response coincident with the ack
    imem_req_fire = 1;
    step();
    imem_req_fire = 0; cfu_req = 1;
    step();
    fetch_cf_ack = 1; imem_rsp_fire = 1;
    #1 check("t4_ack_discard", imem_rsp_discard, 1'b1);
    step();
    idle_inputs();
    #1 check("t4_idle", busy, 1'b0);
    check("t4_allow", imem_req_allow, 1'b1);

    // underflow guard then the request limit
    imem_rsp_fire = 1;
    step();
    imem_rsp_fire = 0; imem_req_fire = 1;
    step(); step();
    imem_req_fire = 0;
    #1 check("t5_limit", imem_req_allow, 1'b0);
    imem_rsp_fire = 1;
    step(); step();
    idle_inputs();

    // asynchronous reset while draining
    imem_req_fire = 1;
    step(); step();
    imem_req_fire = 0; cfu_req = 1;
    step();
    fetch_cf_ack = 1;
    step();
    fetch_cf_ack = 0; cfu_req = 0;
    #1 check("t6_drain_busy", busy, 1'b1);
    #2 g_reset = 1'b1;
    #1 check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", fetch_cf_valid, 1'b0);
    check("t6_rst_target", fetch_cf_target, 64'h0);
    check("t6_rst_allow", imem_req_allow, 1'b1);
    step(); step();
    g_reset = 1'b0;
    fetch_cf_ack = 1;
    for (int i = 0; i < 2; i++) begin
      #1 check("t6_no_ack", cfu_ack | trap_ack | pipe_flush, 1'b0);
      step();
    end
    idle_inputs();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
